// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and fetch-to-EX pipeline register with redirect, stall, halt/resume and retire count
module fetch_sequencer #(
  parameter int unsigned PC_W = 12,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic [31:0]     instr_ex_o,
  output logic [PC_W-1:0] pc_ex_o,
  output logic            valid_ex_o,
  output logic            halted_o,
  output logic [31:0]     retire_cnt_o
);
  typedef enum logic {RUN, HALT} state_t;
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_ex_q, pc_ex_d;
  logic [31:0]     instr_q, instr_d, cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            run, take_halt, take_redir, flush, adv;
  always_comb begin
    run        = state_q == RUN;
    take_halt  = run & halt_i & valid_q;
    take_redir = run & redirect_valid_i & valid_q;
    flush      = take_halt | take_redir;
    adv        = run & ~flush & ~stall_i;
    state_d    = take_halt ? HALT : (!run && resume_i) ? RUN : state_q;
    pc_d       = (flush && redirect_valid_i) ? redirect_pc_i : adv ? pc_q + 1'b1 : pc_q;
    instr_d    = flush ? NOP_INSTR : adv ? imem_rdata_i : instr_q;
    pc_ex_d    = adv ? pc_q : pc_ex_q;
    valid_d    = flush ? 1'b0 : adv ? 1'b1 : valid_q;
    cnt_d      = cnt_q + 32'(run & valid_q & (~stall_i | redirect_valid_i | halt_i));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= '0;
      pc_ex_q <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_ex_q <= pc_ex_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign imem_addr_o  = pc_q;
  assign instr_ex_o   = instr_q;
  assign pc_ex_o      = pc_ex_q;
  assign valid_ex_o   = valid_q;
  assign halted_o     = state_q == HALT;
  assign retire_cnt_o = cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized scoreboard bench for fetch_sequencer against a behavioural model
module tb_fetch_sequencer;
  localparam int PC_W = 12;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef struct {
    int          addr;
    logic [31:0] instr;
    int          pc_ex;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;
  logic            clk, rst_n, stall_i, redirect_valid_i, halt_i, resume_i;
  logic [PC_W-1:0] imem_addr_o, redirect_pc_i, pc_ex_o;
  logic [31:0]     imem_rdata_i, instr_ex_o, retire_cnt_o;
  logic            valid_ex_o, halted_o;
  int              tests, fails;
  exp_t            sb[$];
  int              m_pc, m_pcex;
  logic [31:0]     m_instr, m_cnt;
  logic            m_valid, m_halt;
  fetch_sequencer #(.PC_W(PC_W), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .halt_i(halt_i), .resume_i(resume_i), .instr_ex_o(instr_ex_o), .pc_ex_o(pc_ex_o),
    .valid_ex_o(valid_ex_o), .halted_o(halted_o), .retire_cnt_o(retire_cnt_o)
  );
  function automatic logic [31:0] mem(int a);
    return 32'h9E3779B9 * 32'(a + 1) ^ 32'(a);
  endfunction
  assign imem_rdata_i = mem(int'(imem_addr_o));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step(logic rn, logic st, logic rd, int rpc, logic hl, logic rs);
    @(negedge clk);
    rst_n = rn; stall_i = st; redirect_valid_i = rd; redirect_pc_i = PC_W'(rpc);
    halt_i = hl; resume_i = rs;
    if (!rn) begin
      m_pc = 0; m_pcex = 0; m_instr = NOP; m_valid = 0; m_halt = 0; m_cnt = 0;
    end else if (m_halt) begin
      if (rs) m_halt = 0;
    end else begin
      if (m_valid && (!st || rd || hl)) m_cnt = m_cnt + 1;
      if (hl && m_valid) begin
        m_halt = 1; m_instr = NOP; m_valid = 0;
        if (rd) m_pc = rpc;
      end else if (rd && m_valid) begin
        m_pc = rpc; m_instr = NOP; m_valid = 0;
      end else if (!st) begin
        m_instr = mem(m_pc); m_pcex = m_pc; m_valid = 1; m_pc = (m_pc + 1) % (1 << PC_W);
      end
    end
    sb.push_back('{m_pc, m_instr, m_pcex, m_valid, m_halt, m_cnt});
  endtask
  task automatic idle(int n);
    repeat (n) step(1, 0, 0, 0, 0, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("imem_addr", 32'(imem_addr_o), 32'(e.addr));
        chk("instr_ex", instr_ex_o, e.instr);
        chk("pc_ex", 32'(pc_ex_o), 32'(e.pc_ex));
        chk("valid_ex", 32'(valid_ex_o), 32'(e.valid));
        chk("halted", 32'(halted_o), 32'(e.halted));
        chk("retire_cnt", retire_cnt_o, e.cnt);
      end
    end
  end
  initial begin
    tests = 0; fails = 0;
    rst_n = 0; stall_i = 0; redirect_valid_i = 0; redirect_pc_i = '0; halt_i = 0; resume_i = 0;
    step(0, 1, 1, 5, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    idle(4);
    step(1, 0, 1, 'h040, 0, 0);
    idle(3);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 1, 0);
    repeat (10) step(1, 1, 1, 'h123, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    idle(3);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 'hFFE, 0, 0);
    idle(4);
    step(1, 1, 1, 'h010, 0, 0);
    idle(2);
    step(1, 0, 1, 'h020, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) != 0, $urandom_range(3) == 0, $urandom_range(9) == 0,
           $urandom_range(1) != 0 ? int'($urandom_range(4095)) : int'($urandom_range(4095, 4093)),
           $urandom_range(29) == 0, $urandom_range(4) == 0);
    repeat (4) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
